// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-client round-robin arbiter with a bounded hold time.
//
// One downstream slot is shared among four request sources. The grant is
// registered (one cycle req->gnt latency, no combinational path), handed over
// back-to-back on release, and forcibly rotated after MAX_HOLD cycles when
// another client is waiting, so no client can starve the others.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   req_i[3:0]   level request per client, held for the whole transaction
//   gnt_o[3:0]   registered one-hot grant, zero when idle
//   gnt_idx_o    binary index of granted client, holds last value when idle
//   gnt_valid_o  high whenever gnt_o is non-zero
//   preempt_o    pulse on the first cycle of a grant forced by hold expiry
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8  // 1..255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       preempt_o
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic       preempt_q, preempt_d;

  // Scan clients ptr, ptr+1, ptr+2, ptr+3 (mod 4); first requester wins.
  // Iterating from the farthest offset down lets the nearest one overwrite.
  function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] p);
    pick_t      res;
    logic [1:0] c;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      c = p + 2'(i);
      if (r[c]) begin
        res.found = 1'b1;
        res.idx   = c;
      end
    end
    return res;
  endfunction

  logic [3:0] owner_oh;
  logic [3:0] others;
  logic       owner_req;
  pick_t      pick_all;
  pick_t      pick_oth;

  always_comb begin
    owner_oh  = 4'(1) << gnt_idx_q;
    owner_req = |(req_i & owner_oh);
    others    = req_i & ~owner_oh;
    pick_all  = rr_pick(req_i, ptr_q);
    // ptr_q = owner+1 during a grant, so the owner would be scanned last
    // anyway; masking it just makes the exclusion explicit.
    pick_oth  = rr_pick(others, ptr_q);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    preempt_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_all.found) begin
          state_d    = GRANT;
          gnt_idx_d  = pick_all.idx;
          gnt_d      = 4'(1) << pick_all.idx;
          ptr_d      = pick_all.idx + 2'd1;
          hold_cnt_d = '0;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          // Release: hand over in the same edge, or drop to idle.
          if (pick_oth.found) begin
            gnt_idx_d  = pick_oth.idx;
            gnt_d      = 4'(1) << pick_oth.idx;
            ptr_d      = pick_oth.idx + 2'd1;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (hold_cnt_q == HOLD_LAST) begin
          if (pick_oth.found) begin
            // Hold expired with someone waiting: forced rotation.
            gnt_idx_d  = pick_oth.idx;
            gnt_d      = 4'(1) << pick_oth.idx;
            ptr_d      = pick_oth.idx + 2'd1;
            hold_cnt_d = '0;
            preempt_d  = 1'b1;
          end
          // Sole requester: keep grant, counter stays saturated.
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = (state_q == GRANT);
  assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a MAX_HOLD=4 instance carries the main
// sequence, a MAX_HOLD=1 instance shares the stimulus to cover the
// rotate-every-cycle boundary.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt4, gnt1;
  logic [1:0] idx4, idx1;
  logic       vld4, vld1;
  logic       pre4, pre1;

  int n_chk = 0;
  int n_err = 0;

  rr_arbiter4 #(.MAX_HOLD(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .gnt_o(gnt4), .gnt_idx_o(idx4), .gnt_valid_o(vld4), .preempt_o(pre4)
  );

  rr_arbiter4 #(.MAX_HOLD(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .gnt_o(gnt1), .gnt_idx_o(idx1), .gnt_valid_o(vld1), .preempt_o(pre1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] g, input logic [1:0] i,
                      input logic v, input logic p);
    chk({tag, ".gnt"},  8'(gnt4), 8'(g));
    chk({tag, ".idx"},  8'(idx4), 8'(i));
    chk({tag, ".vld"},  8'(vld4), 8'(v));
    chk({tag, ".pre"},  8'(pre4), 8'(p));
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] ei;
    rst = 1'b1;
    req = 4'b1111;
    #2;

    // Reset held two edges with full request.
    tick(); tick();
    chk4("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("rst.d1.gnt", 8'(gnt1), 8'h00);
    chk("rst.d1.vld", 8'(vld1), 8'h00);

    // Release reset: first grant to client 0, then full-contention rotation.
    rst = 1'b0;
    for (int n = 0; n <= 16; n++) begin
      tick();
      ei = 2'((n / 4) % 4);
      eg = 4'b0001 << ei;
      chk4($sformatf("cont%0d", n), eg, ei, 1'b1, (n % 4 == 0) && (n > 0));
      ei = 2'(n % 4);
      eg = 4'b0001 << ei;
      chk($sformatf("h1.cont%0d.gnt", n), 8'(gnt1), 8'(eg));
      chk($sformatf("h1.cont%0d.pre", n), 8'(pre1), 8'(n > 0));
    end

    // Single client: grant in one cycle, drop to idle one cycle after release.
    rst = 1'b1; req = 4'b0000; tick();
    rst = 1'b0; tick();
    chk4("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0100; tick();
    chk4("single", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    chk4("single.hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000; tick();
    chk4("single.rel", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Sole requester well past MAX_HOLD: never preempted.
    req = 4'b0010;
    for (int n = 0; n < 20; n++) begin
      tick();
      chk($sformatf("sole%0d.gnt", n), 8'(gnt4), 8'h02);
      chk($sformatf("sole%0d.pre", n), 8'(pre4), 8'h00);
    end

    // Handover on release: no zero cycle, no preempt.
    rst = 1'b1; req = 4'b0000; tick();
    rst = 1'b0; req = 4'b0101; tick();
    chk4("ho.own0", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    chk4("ho.own0b", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0100; tick();
    chk4("ho.to2", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Owner 2 releases while 0 and 3 arrive: scan starts at 3.
    req = 4'b1001; tick();
    chk4("simul", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Reset mid-grant, then pointer restarts at 0.
    rst = 1'b1; tick();
    chk4("rst.mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; tick();
    chk4("rst.after", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Hold expiry with 3 waiting: preempt is a single-cycle pulse.
    tick(); tick(); tick();
    chk4("exp.hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    chk4("exp.rot", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick();
    chk4("exp.pulse", 4'b1000, 2'd3, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
